cache_way_fill: RTL
===================

Name: cache_way_fill

Overview:
- Miss-handling and write-path controller for the 4-way set-associative cache. It is the write side of the way-select read mux.
- Takes a miss request plus the four way entries of the addressed set, then picks a victim way.
- Writes back the victim if it is dirty, fetches the line from memory, and drives a one-hot way write-enable with the new packed entry.
- Sits between the cache tag/data arrays and the memory-side interface.

Parameters:
- LINE_SIZE_BYTES, 4, bytes per cache line; LINE_BITS = LINE_SIZE_BYTES*8.
- TAG_BITS, 18, tag width.
- WAYS, 4, number of ways; fixed at 4 (one-hot enables are 4 bits).
- Entry width E = 3 + TAG_BITS + LINE_BITS. Packing, MSB to LSB: valid, lru, dirty, tag, data. Data occupies [LINE_BITS-1:0].

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_req_valid  input  1  miss request valid
- o_req_ready  output  1  high only in IDLE
- i_req_tag  input  TAG_BITS  tag of the missing line
- i_req_write  input  1  miss caused by a store; filled line is marked dirty
- i_req_wdata  input  LINE_BITS  store data; replaces the fetched data when i_req_write=1
- i_way_entry  input  4*E  set entries, way k at [k*E +: E]
- o_wb_valid  output  1  writeback valid
- i_wb_ready  input  1  writeback accepted
- o_wb_tag  output  TAG_BITS  victim tag
- o_wb_data  output  LINE_BITS  victim data
- o_mem_req_valid  output  1  fill request valid
- i_mem_req_ready  input  1  fill request accepted
- o_mem_req_tag  output  TAG_BITS  tag being fetched
- i_mem_rsp_valid  input  1  fill data valid (single beat)
- i_mem_rsp_data  input  LINE_BITS  fill data
- o_way_we  output  4  one-hot way write enable
- o_way_entry  output  E  entry to write
- o_lru_clr  output  4  one-hot-or-zero mask: clear LRU bit of these ways, same cycle as o_way_we
- o_done  output  1  one-cycle completion pulse; o_done_way holds the victim index
- o_done_way  output  2  victim way index

Behaviour:
- Reset (async, i_rst=1): state=IDLE. All outputs 0 except o_req_ready=1. Captured registers cleared. Asserting reset in any state aborts the operation immediately; no partial way write occurs.
- Accept: i_req_valid & o_req_ready at a rising edge. Tag, write, wdata and all four entries are registered that cycle. Later changes on i_way_entry are ignored.
- Victim selection (computed in IDLE from live inputs, registered on accept), in priority order:
  - lowest-index way with valid=0;
  - else lowest-index way with lru=0;
  - else way 0.
- States:
  - IDLE: o_req_ready=1. On accept, go to WB if the victim has valid=1 and dirty=1, else REQ.
  - WB: o_wb_valid=1 with o_wb_tag/o_wb_data held stable until the i_wb_ready handshake, then REQ.
  - REQ: o_mem_req_valid=1, o_mem_req_tag stable, until i_mem_req_ready, then WAIT.
  - WAIT: on i_mem_rsp_valid, capture data, go to WRITE. A response arriving in the same cycle as the REQ handshake is ignored.
  - WRITE (exactly one cycle): o_way_we = one-hot of the victim. o_way_entry = {1, 1, i_req_write, req_tag, data}, where data = i_req_wdata if i_req_write=1, else the fetched data. Go to DONE.
  - DONE (one cycle): o_done=1, o_done_way=victim. Return to IDLE.
- LRU update in WRITE: if the captured lru bits of the other three ways are all 1, o_lru_clr = those three ways, else 0.
- Valid outputs are registered (state-decoded). They never depend combinationally on the ready inputs.
- Minimum latency, clean victim, ready/rsp tied high: accept → REQ → WAIT → WRITE → DONE, i.e. WRITE 3 cycles after accept.
- Only one outstanding request; no new accept until IDLE.

Test Plan:
- Reset mid-WB: o_wb_valid=1, i_wb_ready=0, pulse i_rst → all outputs 0 and o_req_ready=1 the same cycle; no o_way_we afterwards.
- Empty-way fill: way0 valid and way1 invalid, tag=0x2A5, fill data 0xDEADBEEF, i_req_write=0 → no writeback; o_way_we=0010; o_way_entry = {1,1,0,0x2A5,0xDEADBEEF}; o_done_way=1.
- Dirty-victim writeback: all ways valid; lru=1,1,0,1; way2 dirty with tag 0x1F and data 0x12345678, i_wb_ready delayed 3 cycles → o_wb_tag/o_wb_data held stable through the stall; then fill; o_way_we=0100; o_lru_clr=1011.
- Store miss: i_req_write=1, wdata=0xCAFEF00D, fill data 0x0 → o_way_entry dirty=1, data=0xCAFEF00D.
- All lru=1, all clean → victim way0; o_way_we=0001; o_lru_clr=1110; o_req_ready low from accept until DONE; i_req_valid held high across DONE is accepted again only on return to IDLE.

Source files
------------

// File: rtl/cache_way_fill.sv
// Miss-handling / write-path controller for a 4-way set-associative cache:
// victim select, dirty writeback, line fetch, and one-hot way write.
module cache_way_fill #(
  parameter int LINE_SIZE_BYTES = 4,
  parameter int TAG_BITS        = 18,
  parameter int WAYS            = 4
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_req_valid,
  output logic                                        o_req_ready,
  input  logic [TAG_BITS-1:0]                         i_req_tag,
  input  logic                                        i_req_write,
  input  logic [LINE_SIZE_BYTES*8-1:0]                i_req_wdata,
  input  logic [WAYS*(3+TAG_BITS+LINE_SIZE_BYTES*8)-1:0] i_way_entry,
  output logic                                        o_wb_valid,
  input  logic                                        i_wb_ready,
  output logic [TAG_BITS-1:0]                         o_wb_tag,
  output logic [LINE_SIZE_BYTES*8-1:0]                o_wb_data,
  output logic                                        o_mem_req_valid,
  input  logic                                        i_mem_req_ready,
  output logic [TAG_BITS-1:0]                         o_mem_req_tag,
  input  logic                                        i_mem_rsp_valid,
  input  logic [LINE_SIZE_BYTES*8-1:0]                i_mem_rsp_data,
  output logic [3:0]                                  o_way_we,
  output logic [3+TAG_BITS+LINE_SIZE_BYTES*8-1:0]     o_way_entry,
  output logic [3:0]                                  o_lru_clr,
  output logic                                        o_done,
  output logic [1:0]                                  o_done_way
);

  localparam int LINE_BITS = LINE_SIZE_BYTES * 8;
  localparam int E         = 3 + TAG_BITS + LINE_BITS;
  localparam int V_BIT     = E - 1;
  localparam int L_BIT     = E - 2;
  localparam int D_BIT     = E - 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]           state;
  logic [1:0]           victim_q;
  logic [3:0]           lru_q;
  logic [TAG_BITS-1:0]  vtag_q;
  logic [LINE_BITS-1:0] vdata_q;
  logic [TAG_BITS-1:0]  req_tag_q;
  logic                 req_write_q;
  logic [LINE_BITS-1:0] req_wdata_q;
  logic [LINE_BITS-1:0] fill_q;

  logic [1:0]           sel_way;
  logic                 sel_found;
  logic [E-1:0]         sel_entry;
  logic                 accept;

  // Victim priority: first invalid way, then first way with lru=0, else way 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_way   = 2'd0;
    sel_found = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (!sel_found && !i_way_entry[k*E + V_BIT]) begin
        sel_way   = 2'(k);
        sel_found = 1'b1;
      end
    end
    for (int k = 0; k < WAYS; k++) begin
      if (!sel_found && !i_way_entry[k*E + L_BIT]) begin
        sel_way   = 2'(k);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_entry = i_way_entry[sel_way*E +: E];
  assign accept    = i_req_valid && (state == S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      victim_q    <= '0;
      lru_q       <= '0;
      vtag_q      <= '0;
      vdata_q     <= '0;
      req_tag_q   <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            victim_q    <= sel_way;
            vtag_q      <= sel_entry[LINE_BITS +: TAG_BITS];
            vdata_q     <= sel_entry[LINE_BITS-1:0];
            req_tag_q   <= i_req_tag;
            req_write_q <= i_req_write;
            req_wdata_q <= i_req_wdata;
            for (int k = 0; k < WAYS; k++) lru_q[k] <= i_way_entry[k*E + L_BIT];
            state <= (sel_entry[V_BIT] && sel_entry[D_BIT]) ? S_WB : S_REQ;
          end
        end
        S_WB:    if (i_wb_ready)      state <= S_REQ;
        S_REQ:   if (i_mem_req_ready) state <= S_WAIT;
        S_WAIT: begin
          if (i_mem_rsp_valid) begin
            fill_q <= i_mem_rsp_data;
            state  <= S_WRITE;
          end
        end
        S_WRITE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [3:0] victim_oh;
  assign victim_oh = 4'b0001 << victim_q;

  // Outputs decode only the state register and captured data, never the ready
  // inputs; data buses read zero outside the state that qualifies them.
  always_comb begin
    o_req_ready     = (state == S_IDLE);
    o_wb_valid      = 1'b0;
    o_wb_tag        = '0;
    o_wb_data       = '0;
    o_mem_req_valid = 1'b0;
    o_mem_req_tag   = '0;
    o_way_we        = '0;
    o_way_entry     = '0;
    o_lru_clr       = '0;
    o_done          = 1'b0;
    o_done_way      = '0;
    case (state)
      S_WB: begin
        o_wb_valid = 1'b1;
        o_wb_tag   = vtag_q;
        o_wb_data  = vdata_q;
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_tag   = req_tag_q;
      end
      S_WRITE: begin
        o_way_we    = victim_oh;
        o_way_entry = {1'b1, 1'b1, req_write_q, req_tag_q,
                       req_write_q ? req_wdata_q : fill_q};
        // Once the other three ways all carry lru=1, reset them so the
        // pseudo-LRU state never saturates.
        if ((lru_q | victim_oh) == 4'hF) o_lru_clr = ~victim_oh;
      end
      S_DONE: begin
        o_done     = 1'b1;
        o_done_way = victim_q;
      end
      default: ;
    endcase
  end

endmodule
